// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared definitions for the ROM loader frame parser.
//   LDR_CMD_WRITE / LDR_CMD_DONE : frame command bytes
//   LDR_ADDR_BYTES               : number of address bytes in a WRITE_BLOCK frame
//   ldr_state_t                  : parser state; ST_CSUM exists only when
//                                  ROM_LOADER_CSUM_EN is defined
package rom_loader_pkg;

    localparam logic [7:0] LDR_CMD_WRITE  = 8'hA5;
    localparam logic [7:0] LDR_CMD_DONE   = 8'h5A;
    localparam int         LDR_ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA
`ifdef ROM_LOADER_CSUM_EN
        , ST_CSUM
`endif
    } ldr_state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader: parses the MCU byte stream into loader-bus writes.
//
// Frame: cmd, 4 address bytes (MSB first), LEN_W/8 length bytes (MSB first),
// N data bytes, and a trailing checksum byte when ROM_LOADER_CSUM_EN is
// defined (8-bit sum of address, length and data bytes).
//
// Parameters:
//   LEN_W       length field width; multiple of 8 in the range 16..32
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   rx_data     byte from the MCU link
//   rx_valid    one-cycle qualifier for rx_data
//   rx_first    with rx_valid, marks a command byte (resyncs from any state)
//   loader_act  loader session active (set by WRITE_BLOCK, cleared by DONE)
//   loader_a    write address, auto-incrementing, wraps at 2^32
//   loader_d    write data
//   loader_wr   one-cycle write strobe, one cycle after the data byte
//   busy        parser is not idle
//   err         sticky error (unknown command, checksum mismatch);
//               cleared by WRITE_BLOCK
//
// Handshake: rx_valid is a pure strobe with no backpressure; every qualified
// byte is consumed in the cycle it arrives, and all outputs are registered.
//
// Optional feature macro: ROM_LOADER_CSUM_EN (checksum byte and ST_CSUM).
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_first,
    output logic        loader_act,
    output logic [31:0] loader_a,
    output logic [7:0]  loader_d,
    output logic        loader_wr,
    output logic        busy,
    output logic        err
);

    localparam int LEN_BYTES = LEN_W / 8;

    // State the parser enters after the last data byte (or a zero length).
`ifdef ROM_LOADER_CSUM_EN
    localparam ldr_state_t END_STATE = ST_CSUM;
    localparam logic       END_BUSY  = 1'b1;
`else
    localparam ldr_state_t END_STATE = ST_IDLE;
    localparam logic       END_BUSY  = 1'b0;
`endif

    ldr_state_t       state;
    logic [1:0]       byte_cnt;
    logic [23:0]      addr_sh;    // first three address bytes
    logic [31:0]      wr_addr;    // address of the next data byte
    logic [LEN_W-1:0] remaining;  // length shift register, then byte countdown
    logic [LEN_W-1:0] len_next;
`ifdef ROM_LOADER_CSUM_EN
    logic [7:0]       csum;
    logic [7:0]       csum_add;
`endif

    always_comb begin
        len_next = {remaining[LEN_W-9:0], rx_data};
`ifdef ROM_LOADER_CSUM_EN
        csum_add = csum + rx_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            byte_cnt   <= '0;
            addr_sh    <= '0;
            wr_addr    <= '0;
            remaining  <= '0;
            loader_act <= 1'b0;
            loader_a   <= '0;
            loader_d   <= '0;
            loader_wr  <= 1'b0;
            err        <= 1'b0;
`ifdef ROM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            loader_wr <= 1'b0;
            if (rx_valid && rx_first) begin
                // A command byte is decoded in any state; an unfinished
                // frame is simply dropped.
                byte_cnt <= '0;
`ifdef ROM_LOADER_CSUM_EN
                csum     <= '0;
`endif
                case (rx_data)
                    LDR_CMD_WRITE: begin
                        loader_act <= 1'b1;
                        err        <= 1'b0;
                        state      <= ST_ADDR;
                        busy       <= 1'b1;
                    end
                    LDR_CMD_DONE: begin
                        loader_act <= 1'b0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (rx_valid) begin
                case (state)
                    ST_ADDR: begin
                        addr_sh <= {addr_sh[15:0], rx_data};
`ifdef ROM_LOADER_CSUM_EN
                        csum    <= csum_add;
`endif
                        if (byte_cnt == 2'(LDR_ADDR_BYTES - 1)) begin
                            loader_a <= {addr_sh, rx_data};
                            wr_addr  <= {addr_sh, rx_data};
                            byte_cnt <= '0;
                            state    <= ST_LEN;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    ST_LEN: begin
                        remaining <= len_next;
`ifdef ROM_LOADER_CSUM_EN
                        csum      <= csum_add;
`endif
                        if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                            byte_cnt <= '0;
                            if (len_next == '0) begin
                                state <= END_STATE;
                                busy  <= END_BUSY;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    ST_DATA: begin
                        loader_wr <= 1'b1;
                        loader_a  <= wr_addr;
                        loader_d  <= rx_data;
                        wr_addr   <= wr_addr + 32'd1;
                        remaining <= remaining - LEN_W'(1);
`ifdef ROM_LOADER_CSUM_EN
                        csum      <= csum_add;
`endif
                        if (remaining == LEN_W'(1)) begin
                            state <= END_STATE;
                            busy  <= END_BUSY;
                        end
                    end
`ifdef ROM_LOADER_CSUM_EN
                    ST_CSUM: begin
                        if (rx_data != csum) begin
                            err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
`endif
                    default: begin
                        // Stray byte in IDLE: ignored.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: self-checking bench for rom_loader. Frames are built from
// a base address and a byte list; the expected write list is base+i / byte i,
// and session flags follow the command rules.
module tb_rom_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_first;
    logic        loader_act;
    logic [31:0] loader_a;
    logic [7:0]  loader_d;
    logic        loader_wr;
    logic        busy;
    logic        err;

    rom_loader #(.LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .loader_act (loader_act),
        .loader_a   (loader_a),
        .loader_d   (loader_d),
        .loader_wr  (loader_wr),
        .busy       (busy),
        .err        (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];
    int          obs_t[$];
    logic [7:0]  frame_data[$];
    logic        model_act;
    logic        model_err;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (loader_wr === 1'b1) begin
            obs_q.push_back({loader_a, loader_d});
            obs_t.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_first = first;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_first = 1'b0;
    endtask

    // Sends a WRITE_BLOCK frame of length n using frame_data; only the first
    // stop_at data bytes are sent (stop_at < n leaves the frame unfinished).
    task automatic send_write(input logic [31:0] base, input int n,
                              input int stop_at, input logic bad_csum);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [15:0] len;
        sum = 8'h00;
        len = 16'(n);
        send_byte(8'hA5, 1'b1);
        model_act = 1'b1;
        model_err = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            b = base[8*i +: 8];
            sum = sum + b;
            send_byte(b, 1'b0);
        end
        for (int i = 1; i >= 0; i--) begin
            b = len[8*i +: 8];
            sum = sum + b;
            send_byte(b, 1'b0);
        end
        for (int i = 0; i < stop_at; i++) begin
            b = frame_data[i];
            sum = sum + b;
            send_byte(b, 1'b0);
            exp_q.push_back({base + 32'(i), b});
        end
`ifdef ROM_LOADER_CSUM_EN
        if (stop_at == n) begin
            b = bad_csum ? 8'h00 : sum;
            send_byte(b, 1'b0);
            if (b != sum) model_err = 1'b1;
        end
`else
        if (bad_csum && sum == 8'h00) model_err = model_err;
`endif
    endtask

    task automatic fill_random(input int n);
        frame_data.delete();
        for (int i = 0; i < n; i++) frame_data.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_first = 1'b0;
        rx_data = 8'h00;
        idle(3);
        checks += 6;
        if (loader_act !== 1'b0) begin errors++; $display("FAIL reset_act got %b exp 0", loader_act); end
        if (loader_a !== 32'h0) begin errors++; $display("FAIL reset_a got %h exp 0", loader_a); end
        if (loader_d !== 8'h0) begin errors++; $display("FAIL reset_d got %h exp 0", loader_d); end
        if (loader_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", loader_wr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        reset = 1'b0;
        model_act = 1'b0;
        model_err = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        clear_sb();
        frame_data = '{8'h11, 8'h22, 8'h33};
        send_write(32'h0000_1000, 3, 3, 1'b0);
        idle(2);
        checks += 5;
        if (obs_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", obs_q.size()); end
        if (obs_q.size() > 0 && obs_q[0] !== {32'h1000, 8'h11}) begin errors++; $display("FAIL basic_w0 got %h exp 000000100011", obs_q[0]); end
        if (obs_q.size() > 2 && obs_q[2] !== {32'h1002, 8'h33}) begin errors++; $display("FAIL basic_w2 got %h exp 000010023 3", obs_q[2]); end
        if (loader_act !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL basic_flags got act=%b err=%b exp act=1 err=0", loader_act, err); end
        if (loader_a !== 32'h1002) begin errors++; $display("FAIL basic_hold_a got %h exp 00001002", loader_a); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        clear_sb();
        base = $urandom;
        fill_random(256);
        send_write(base, 256, 256, 1'b0);
        idle(2);
        checks += 2;
        if (obs_q.size() != 256) begin errors++; $display("FAIL b2b_count got %0d exp 256", obs_q.size()); end
        else if (obs_t[255] - obs_t[0] != 255) begin errors++; $display("FAIL b2b_gapless got span %0d exp 255", obs_t[255] - obs_t[0]); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (loader_act !== 1'b1) begin errors++; $display("FAIL done_before got act=%b exp 1", loader_act); end
        send_byte(8'h5A, 1'b1);
        model_act = 1'b0;
        checks += 2;
        if (loader_act !== model_act) begin errors++; $display("FAIL done_act got %b exp %b", loader_act, model_act); end
        if (err !== model_err || busy !== 1'b0) begin errors++; $display("FAIL done_flags got err=%b busy=%b exp err=%b busy=0", err, busy, model_err); end
    endtask

    task automatic test_wrap();
        clear_sb();
        fill_random(3);
        send_write(32'hFFFF_FFFE, 3, 3, 1'b0);
        idle(2);
        checks++;
        if (obs_q.size() != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q.size() == 3 && obs_q[2][39:8] !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", obs_q[2][39:8]); end
    endtask

    task automatic test_unknown_zero();
        clear_sb();
        send_byte(8'h33, 1'b1);
        model_err = 1'b1;
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL unknown_err got %b exp 1", err); end
        if (busy !== 1'b0 || loader_act !== model_act) begin errors++; $display("FAIL unknown_state got busy=%b act=%b exp busy=0 act=%b", busy, loader_act, model_act); end
        // Stray byte in IDLE must not write or change err.
        send_byte(8'hA5, 1'b0);
        idle(1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stray got err=%b busy=%b exp err=1 busy=0", err, busy); end
        frame_data.delete();
        send_write(32'h8000_0040, 0, 0, 1'b0);
        idle(2);
        checks += 3;
        if (obs_q.size() != 0) begin errors++; $display("FAIL zero_len_count got %0d exp 0", obs_q.size()); end
        if (err !== 1'b0 || loader_act !== 1'b1) begin errors++; $display("FAIL zero_len_flags got err=%b act=%b exp err=0 act=1", err, loader_act); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %b exp 0", busy); end
    endtask

    task automatic test_resync();
        clear_sb();
        fill_random(6);
        send_write(32'h0000_2000, 6, 3, 1'b0);
        fill_random(4);
        send_write(32'h8000_0100, 4, 4, 1'b0);
        idle(2);
        checks += 2;
        if (obs_q.size() != 7) begin errors++; $display("FAIL resync_count got %0d exp 7", obs_q.size()); end
        if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL resync_flags got busy=%b err=%b exp 0 0", busy, err); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL resync_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        int stop;
        logic [31:0] base;
        clear_sb();
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(0, 8);
            stop = (f < 7 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n;
            base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            fill_random(n);
            send_write(base, n, stop, 1'b0);
            if (stop == n) begin
                if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
                idle($urandom_range(0, 2));
            end
        end
        idle(2);
        checks += 2;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        if (err !== model_err || loader_act !== model_act) begin errors++; $display("FAIL random_flags got err=%b act=%b exp err=%b act=%b", err, loader_act, model_err, model_act); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

`ifdef ROM_LOADER_CSUM_EN
    task automatic test_bad_csum();
        clear_sb();
        frame_data = '{8'h11, 8'h22, 8'h33};
        send_write(32'h0000_1000, 3, 3, 1'b1);
        idle(2);
        checks += 2;
        if (obs_q.size() != 3) begin errors++; $display("FAIL csum_count got %0d exp 3", obs_q.size()); end
        if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL csum_err got err=%b busy=%b exp err=1 busy=0", err, busy); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL csum_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask
`endif

    task automatic test_reset_mid_data();
        clear_sb();
        fill_random(5);
        send_write(32'h0000_3000, 5, 2, 1'b0);
        // Third data byte arrives together with reset: its strobe is dropped.
        rx_data  = 8'hC3;
        rx_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reset    = 1'b0;
        model_act = 1'b0;
        model_err = 1'b0;
        checks += 3;
        if (loader_act !== 1'b0 || loader_wr !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got act=%b wr=%b busy=%b err=%b exp all 0", loader_act, loader_wr, busy, err);
        end
        if (loader_a !== 32'h0 || loader_d !== 8'h0) begin errors++; $display("FAIL rst_mid_bus got a=%h d=%h exp 0 0", loader_a, loader_d); end
        idle(2);
        if (obs_q.size() != 2) begin errors++; $display("FAIL rst_mid_count got %0d exp 2", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_unknown_zero();
        test_resync();
        test_random();
`ifdef ROM_LOADER_CSUM_EN
        test_bad_csum();
`endif
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Frame parser that drives the loader write port of the on-chip ROM and other loadable memories. It consumes the byte stream delivered by the MCU SPI link, decodes write-block and done commands, and emits `loader_act`, `loader_a`, `loader_d` and single-cycle `loader_wr` strobes with an auto-incrementing address. It sits between the MCU interface and every memory that accepts the loader bus.

## Interface
Parameters:
- `LEN_W`, 16: width of the frame length field; length is sent as `LEN_W/8` bytes, MSB first.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the MCU link.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`; may be high every cycle.
- `rx_first`  in  1  qualified by `rx_valid`; marks the first byte (command) of a frame.
- `loader_act`  out  1  loader session active.
- `loader_a`  out  32  write address; bit 31 set selects non-ROM targets downstream.
- `loader_d`  out  8  write data.
- `loader_wr`  out  1  one-cycle write strobe.
- `busy`  out  1  high while a frame is being parsed, i.e. state is not IDLE.
- `err`  out  1  sticky frame error flag.

## Operation
- Commands: `8'hA5` = WRITE_BLOCK, `8'h5A` = DONE. Any other command byte sets `err` and returns to IDLE.
- WRITE_BLOCK frame: cmd, 4 address bytes (MSB first), 2 length bytes (MSB first), N data bytes, plus a checksum byte when configured.
- States: IDLE -> ADDR (byte count 0..3) -> LEN (0..1) -> DATA (N bytes) -> [CSUM] -> IDLE.
- Zero-length frames: when N = 0, LEN goes directly to CSUM or IDLE.
- Session control:
  - WRITE_BLOCK sets `loader_act` and clears `err`.
  - DONE clears `loader_act` and leaves `err` unchanged.
- Data writes: each data byte produces exactly one `loader_wr` with `loader_a` = frame base address + byte index.
- Address arithmetic: `loader_a` is a 32-bit increment that wraps from `32'hFFFFFFFF` to 0. The length counter is `LEN_W` bits.
- Resynchronisation: `rx_first` with `rx_valid` in any state other than IDLE abandons the current frame without error and decodes `rx_data` as a new command. Bytes already written stay written.
- Stray bytes: a byte without `rx_first` arriving in IDLE is ignored and does not set `err`.

## Timing
- Reset values: `loader_act`=0, `loader_a`=0, `loader_d`=0, `loader_wr`=0, `busy`=0, `err`=0; state = IDLE.
- All outputs are registered.
- Write latency: `loader_wr` rises on the cycle after the `rx_valid` cycle carrying the data byte. `loader_a` and `loader_d` are valid in that same cycle.
- Throughput: back-to-back `rx_valid` is sustained at one write per cycle with no stalls; there is no backpressure.
- `loader_a` keeps the last written address after a frame ends. It is reloaded when the final address byte is received.
- `loader_act` and `err` change on the cycle after the relevant command or checksum byte.
- Reset during DATA: the strobe in flight is dropped and `loader_act` falls next cycle.

## Configuration
- `ROM_LOADER_CSUM_EN` defined:
  - An 8-bit modular sum is taken over the address, length and data bytes.
  - The trailing byte is compared with that sum; a mismatch sets `err`.
  - Writes are not rolled back on a mismatch.
- Not defined:
  - There is no CSUM state and no checksum byte.
  - The frame ends after the last data byte.
  - `err` is set only by unknown commands.

## Structure
- `rom_loader_pkg` holds:
  - command constants `LDR_CMD_WRITE` and `LDR_CMD_DONE`;
  - the state enum `ldr_state_t`;
  - `LDR_ADDR_BYTES` = 4.
- No sub-module is warranted. The byte counters, length counter and checksum accumulator stay inline.

## Test plan
- Basic write: after reset, send A5, 00 00 10 00, 00 03, 11 22 33 [csum 0x79].
  - Required: three `loader_wr` pulses at 0x1000/11, 0x1001/22, 0x1002/33.
  - Required: `loader_act`=1, `err`=0.
- Back-to-back and DONE: send 256 data bytes on consecutive cycles, then 5A.
  - Required: 256 consecutive strobes with no gaps.
  - Required: `loader_act` falls one cycle after the DONE byte.
- Wrap and bit 31: use address FF FF FF FE with length 3.
  - Required: writes at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Unknown and zero-length frames:
  - Command 0x33 -> `err`=1 and state returns to IDLE.
  - A later A5 frame with length 00 00 -> no strobes, and `err` clears.
- Resync: assert `rx_first` with byte A5 in the middle of DATA.
  - Required: the old frame is abandoned and the new address is honoured.
  - Required: no stray strobe appears.
- With `ROM_LOADER_CSUM_EN`:
  - Wrong checksum 0x00 -> data written and `err`=1.
  - Reset asserted mid-DATA -> all outputs 0 on the next cycle.
